// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver with blanking, blink, guard interval and frame-synchronous update.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zeros when a new frame is latched.
module seg_scan_driver #(
    parameter int unsigned DIGITS       = 6,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned GUARD        = 2,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter int unsigned COMMON_ANODE = 0,
    parameter int unsigned DIG_ACT_LOW  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd_data,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  load,
    output logic [6:0]            seg_data,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [6:0]        SEG_OFF = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] DIG_OFF = (DIG_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    typedef struct packed {
        logic [BW-1:0]     bcd;
        logic [DIGITS-1:0] blank;
        logic [DIGITS-1:0] blink;
    } disp_t;

    logic [PW-1:0]     cnt, cnt_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [FW-1:0]     fcnt, fcnt_nxt;
    logic              phase, phase_nxt;
    disp_t             pend, pend_nxt;
    disp_t             disp, disp_nxt;
    disp_t             in_word, src, latched;
    logic              slot_end, wrap, frame_end, in_guard, dark;
    logic [3:0]        code;
    logic [6:0]        seg_nxt;
    logic [DIGITS-1:0] dig_nxt;

    // Active-high segment pattern {a..g}; non-decimal codes render dark.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h7E;
            4'd1:    s = 7'h30;
            4'd2:    s = 7'h6D;
            4'd3:    s = 7'h79;
            4'd4:    s = 7'h33;
            4'd5:    s = 7'h5B;
            4'd6:    s = 7'h1F;
            4'd7:    s = 7'h70;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h73;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Zero digits above the most significant nonzero digit; digit 0 always shows.
    function automatic logic [DIGITS-1:0] lz_mask(input logic [BW-1:0] bcd);
        logic              seen;
        logic [DIGITS-1:0] m;
        seen = 1'b0;
        m    = '0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            if (bcd[4*i +: 4] != 4'h0) seen = 1'b1;
            m[i] = ~seen;
        end
        return m;
    endfunction
`endif

    // Scan timing, blink phase and two-stage data path.
    always_comb begin
        in_word  = '{bcd: bcd_data, blank: blank_mask, blink: blink_mask};
        slot_end = (cnt == PW'(SCAN_DIV - 1));
        wrap     = slot_end && (idx == IW'(DIGITS - 1));
        cnt_nxt  = slot_end ? '0 : cnt + PW'(1);
        idx_nxt  = idx;
        if (slot_end) idx_nxt = wrap ? '0 : idx + IW'(1);

        frame_end = wrap && (fcnt == FW'(BLINK_FRAMES - 1));
        fcnt_nxt  = fcnt;
        if (wrap) fcnt_nxt = frame_end ? '0 : fcnt + FW'(1);
        phase_nxt = phase ^ frame_end;

        pend_nxt = load ? in_word : pend;
        src      = load ? in_word : pend;
        latched  = src;
`ifdef LEADING_ZERO_BLANK_EN
        latched.blank = src.blank | lz_mask(src.bcd);
`endif
        disp_nxt = wrap ? latched : disp;
    end

    // Output pattern for the slot position the counters are about to hold.
    always_comb begin
        code    = 4'h0;
        dark    = 1'b0;
        dig_nxt = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_nxt == IW'(i)) begin
                code       = disp_nxt.bcd[4*i +: 4];
                dark       = disp_nxt.blank[i] | (disp_nxt.blink[i] & phase_nxt);
                dig_nxt[i] = 1'b1;
            end
        end
        in_guard = (32'(cnt_nxt) < GUARD);
        seg_nxt  = dark ? 7'h00 : decode(code);
        if (in_guard) begin
            seg_nxt = SEG_OFF;
            dig_nxt = DIG_OFF;
        end else begin
            seg_nxt = seg_nxt ^ SEG_OFF;
            dig_nxt = dig_nxt ^ DIG_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            fcnt       <= '0;
            phase      <= 1'b0;
            pend       <= '0;
            disp       <= '0;
            seg_data   <= SEG_OFF;
            dig_sel    <= DIG_OFF;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            fcnt       <= fcnt_nxt;
            phase      <= phase_nxt;
            pend       <= pend_nxt;
            disp       <= disp_nxt;
            seg_data   <= seg_nxt;
            dig_sel    <= dig_nxt;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (DIGITS=4, SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2) plus an inverted-polarity instance.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcd_data = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  blink_mask = '0;
    logic        load = 1'b0;
    logic [6:0]  seg_data;
    logic [3:0]  dig_sel;
    logic        frame_done;

    logic [15:0] bcd2 = 16'h8888;
    logic [3:0]  zero4 = 4'h0;
    logic        load2 = 1'b1;
    logic [6:0]  seg2;
    logic [3:0]  dig2;
    logic        fd2;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_cap [16];
    logic [3:0] dig_cap [16];
    logic       fd_cap  [16];

    always #5 clk = ~clk;

    seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .GUARD(1), .BLINK_FRAMES(2),
                      .COMMON_ANODE(0), .DIG_ACT_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .bcd_data(bcd_data), .blank_mask(blank_mask),
        .blink_mask(blink_mask), .load(load), .seg_data(seg_data), .dig_sel(dig_sel),
        .frame_done(frame_done));

    seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .GUARD(1), .BLINK_FRAMES(2),
                      .COMMON_ANODE(1), .DIG_ACT_LOW(1)) dut_inv (
        .clk(clk), .rst_n(rst_n), .bcd_data(bcd2), .blank_mask(zero4),
        .blink_mask(zero4), .load(load2), .seg_data(seg2), .dig_sel(dig2),
        .frame_done(fd2));

    // Expected active-high pattern at frame cycle k for slots packed {d3,d2,d1,d0}.
    function automatic logic [6:0] exp_seg(input int k, input logic [27:0] s);
        if (k % 4 == 0) return 7'h00;
        return s[7*(k/4) +: 7];
    endfunction

    function automatic logic [3:0] exp_dig(input int k);
        if (k % 4 == 0) return 4'h0;
        return 4'(1 << (k / 4));
    endfunction

    task automatic wait_frame();
        for (int n = 0; n < 64; n++) begin
            if (frame_done === 1'b1) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL wait_frame: frame_done not seen within 64 cycles");
    endtask

    task automatic capture_frame();
        wait_frame();
        for (int k = 0; k < 16; k++) begin
            seg_cap[k] = seg_data;
            dig_cap[k] = dig_sel;
            fd_cap[k]  = frame_done;
            if (k < 15) @(negedge clk);
        end
    endtask

    task automatic load_word(input logic [15:0] b, input logic [3:0] bl, input logic [3:0] bk);
        bcd_data = b; blank_mask = bl; blink_mask = bk; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bcd_data = 16'h9999; load = 1'b1;
        @(negedge clk);
        checks++;
        if (seg_data !== 7'h00 || dig_sel !== 4'h0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: seg=%h dig=%b fd=%b, want 00 0000 0", seg_data, dig_sel, frame_done);
        end
        checks++;
        if (seg2 !== 7'h7F || dig2 !== 4'hF || fd2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_inv: seg=%h dig=%b fd=%b, want 7f 1111 0", seg2, dig2, fd2);
        end
        load = 1'b0;
        rst_n = 1'b1;
        // Load during reset must be ignored: display and pending stay zero.
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (seg_cap[k] !== exp_seg(k, {4{7'h7E}}) || dig_cap[k] !== exp_dig(k)) begin
                errors++;
                $display("FAIL reset_load_ignored k=%0d: seg=%h dig=%b, want %h %b",
                         k, seg_cap[k], dig_cap[k], exp_seg(k, {4{7'h7E}}), exp_dig(k));
            end
        end
    endtask

    task automatic test_scan();
        int n;
        load_word(16'h1234, 4'h0, 4'h0);
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (seg_cap[k] !== exp_seg(k, {7'h30, 7'h6D, 7'h79, 7'h33}) || dig_cap[k] !== exp_dig(k)
                || fd_cap[k] !== (k == 0)) begin
                errors++;
                $display("FAIL scan_1234 k=%0d: seg=%h dig=%b fd=%b, want %h %b %b", k, seg_cap[k],
                         dig_cap[k], fd_cap[k], exp_seg(k, {7'h30, 7'h6D, 7'h79, 7'h33}), exp_dig(k), k == 0);
            end
        end
        wait_frame();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 40);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL frame_period: %0d cycles, want 16", n);
        end
    endtask

    task automatic test_midframe();
        wait_frame();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (seg_data !== exp_seg(k, {7'h30, 7'h6D, 7'h79, 7'h33}) || dig_sel !== exp_dig(k)) begin
                errors++;
                $display("FAIL midframe_no_tear k=%0d: seg=%h dig=%b, want %h %b", k, seg_data, dig_sel,
                         exp_seg(k, {7'h30, 7'h6D, 7'h79, 7'h33}), exp_dig(k));
            end
            if (k == 3) begin bcd_data = 16'h1111; load = 1'b1; end
            if (k == 6) begin bcd_data = 16'h5678; load = 1'b1; end
            if (k == 4 || k == 7) load = 1'b0;
            @(negedge clk);
        end
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (seg_cap[k] !== exp_seg(k, {7'h5B, 7'h1F, 7'h70, 7'h7F}) || dig_cap[k] !== exp_dig(k)) begin
                errors++;
                $display("FAIL midframe_next k=%0d: seg=%h dig=%b, want %h %b", k, seg_cap[k], dig_cap[k],
                         exp_seg(k, {7'h5B, 7'h1F, 7'h70, 7'h7F}), exp_dig(k));
            end
        end
    endtask

    task automatic test_load_on_wrap();
        // capture_frame left us at the last cycle of a frame; this load lands on the wrap edge.
        load_word(16'h9021, 4'h0, 4'h0);
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (seg_cap[k] !== exp_seg(k, {7'h73, 7'h7E, 7'h6D, 7'h30}) || dig_cap[k] !== exp_dig(k)) begin
                errors++;
                $display("FAIL load_on_wrap k=%0d: seg=%h dig=%b, want %h %b", k, seg_cap[k], dig_cap[k],
                         exp_seg(k, {7'h73, 7'h7E, 7'h6D, 7'h30}), exp_dig(k));
            end
        end
    endtask

    task automatic test_blank_code();
        load_word(16'h3A5A, 4'b0010, 4'h0);
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (seg_cap[k] !== exp_seg(k, {7'h79, 7'h00, 7'h00, 7'h00}) || dig_cap[k] !== exp_dig(k)) begin
                errors++;
                $display("FAIL blank_code k=%0d: seg=%h dig=%b, want %h %b", k, seg_cap[k], dig_cap[k],
                         exp_seg(k, {7'h79, 7'h00, 7'h00, 7'h00}), exp_dig(k));
            end
        end
    endtask

    task automatic test_blink();
        logic [6:0] want0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        load_word(16'h1234, 4'h0, 4'b0001);
        for (int f = 1; f <= 6; f++) begin
            capture_frame();
            want0 = (f == 1 || f == 4 || f == 5) ? 7'h33 : 7'h00;
            checks++;
            if (seg_cap[1] !== want0 || dig_cap[1] !== 4'b0001) begin
                errors++;
                $display("FAIL blink_d0 frame=%0d: seg=%h dig=%b, want %h 0001", f, seg_cap[1], dig_cap[1], want0);
            end
            checks++;
            if (seg_cap[5] !== 7'h79 || seg_cap[13] !== 7'h30) begin
                errors++;
                $display("FAIL blink_steady frame=%0d: d1=%h d3=%h, want 79 30", f, seg_cap[5], seg_cap[13]);
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [27:0] want;
`ifdef LEADING_ZERO_BLANK_EN
        want = {7'h00, 7'h00, 7'h70, 7'h7E};
`else
        want = {7'h7E, 7'h7E, 7'h70, 7'h7E};
`endif
        load_word(16'h0070, 4'h0, 4'h0);
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (seg_cap[k] !== exp_seg(k, want)) begin
                errors++;
                $display("FAIL lz_0070 k=%0d: seg=%h, want %h", k, seg_cap[k], exp_seg(k, want));
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        want = {7'h00, 7'h00, 7'h00, 7'h7E};
`else
        want = {4{7'h7E}};
`endif
        load_word(16'h0000, 4'h0, 4'h0);
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (seg_cap[k] !== exp_seg(k, want)) begin
                errors++;
                $display("FAIL lz_0000 k=%0d: seg=%h, want %h", k, seg_cap[k], exp_seg(k, want));
            end
        end
    endtask

    task automatic test_polarity();
        int n;
        n = 0;
        while (fd2 !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (fd2 !== 1'b1) begin
            errors++;
            $display("FAIL polarity_sync: fd2=%b, want 1", fd2);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (seg2 !== ((k % 4 == 0) ? 7'h7F : 7'h00) || dig2 !== ~exp_dig(k)) begin
                errors++;
                $display("FAIL polarity k=%0d: seg=%h dig=%b, want %h %b", k, seg2, dig2,
                         (k % 4 == 0) ? 7'h7F : 7'h00, ~exp_dig(k));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        load_word(16'h1234, 4'h0, 4'h0);
        wait_frame();
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (seg_data !== 7'h00 || dig_sel !== 4'h0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_dark: seg=%h dig=%b fd=%b, want 00 0000 0", seg_data, dig_sel, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (seg_data !== 7'h7E || dig_sel !== 4'b0001) begin
            errors++;
            $display("FAIL reset_mid_restart: seg=%h dig=%b, want 7e 0001", seg_data, dig_sel);
        end
        n = 1;
        while (frame_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL reset_mid_frame: first frame_done after %0d cycles, want 16", n);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_midframe();
        test_load_on_wrap();
        test_blank_code();
        test_polarity();
        test_blink();
        test_leading_zero();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
